// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - two-client arbiter and strobe sequencer for the external async SRAM
module sram_access_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int ARB_MODE      = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  typedef enum logic [1:0] {IDLE, WRITE, RECOVER, READ} state_t;
  typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            state;
  grant_t            last_grant;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              dq_oe;
  logic              grant_wr;

  // On a tie the write wins in fixed-priority mode, otherwise whoever went last yields.
  assign grant_wr = i_wr_req &&
                    (!i_rd_req || (ARB_MODE != 0) || (last_grant == GRANT_READ));

  assign io_SRAM_DQ = dq_oe ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_READ;
      cnt         <= '0;
      wdata_q     <= '0;
      dq_oe       <= 1'b0;
      o_SRAM_ADDR <= '0;
      o_SRAM_WE_N <= 1'b1;
      o_SRAM_CE_N <= 1'b1;
      o_SRAM_OE_N <= 1'b1;
      o_SRAM_LB_N <= 1'b1;
      o_SRAM_UB_N <= 1'b1;
      o_rd_data   <= '0;
      o_wr_ack    <= 1'b0;
      o_rd_ack    <= 1'b0;
      o_rd_valid  <= 1'b0;
    end else begin
      o_wr_ack   <= 1'b0;
      o_rd_ack   <= 1'b0;
      o_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state       <= WRITE;
            last_grant  <= GRANT_WRITE;
            cnt         <= CNT_LOAD;
            o_SRAM_ADDR <= i_wr_addr;
            wdata_q     <= i_wr_data;
            dq_oe       <= 1'b1;
            o_wr_ack    <= 1'b1;
            o_SRAM_WE_N <= 1'b0;
            o_SRAM_CE_N <= 1'b0;
            o_SRAM_OE_N <= 1'b1;
            o_SRAM_LB_N <= 1'b0;
            o_SRAM_UB_N <= 1'b0;
          end else if (i_rd_req) begin
            state       <= READ;
            last_grant  <= GRANT_READ;
            cnt         <= CNT_LOAD;
            o_SRAM_ADDR <= i_rd_addr;
            o_rd_ack    <= 1'b1;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_CE_N <= 1'b0;
            o_SRAM_OE_N <= 1'b0;
            o_SRAM_LB_N <= 1'b0;
            o_SRAM_UB_N <= 1'b0;
          end
        end
        WRITE: begin
          if (cnt == 4'd0) begin
            state       <= RECOVER;
            o_SRAM_WE_N <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RECOVER: begin
          // Address and data were held one cycle past WE_N rising; release everything now.
          state       <= IDLE;
          dq_oe       <= 1'b0;
          o_SRAM_CE_N <= 1'b1;
          o_SRAM_LB_N <= 1'b1;
          o_SRAM_UB_N <= 1'b1;
        end
        READ: begin
          if (cnt == 4'd0) begin
            state       <= IDLE;
            o_rd_data   <= io_SRAM_DQ;
            o_rd_valid  <= 1'b1;
            o_SRAM_CE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b1;
            o_SRAM_LB_N <= 1'b1;
            o_SRAM_UB_N <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - scoreboard bench for sram_access_arbiter
module tb_sram_access_arbiter;

  localparam logic [1:0] K_WACK = 2'd0, K_RACK = 2'd1, K_RVALID = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [19:0] addr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [19:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack, rd_ack, rd_valid;
  logic [15:0] rd_data;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;

  logic        wr_req1 = 1'b0, rd_req1 = 1'b0;
  logic [19:0] wr_addr1 = 20'h00AAA, rd_addr1 = 20'h00BBB;
  logic [15:0] wr_data1 = 16'h5A5A;
  logic        wr_ack1, rd_ack1, rd_valid1;
  logic [15:0] rd_data1;
  logic [19:0] sram_addr1;
  wire  [15:0] sram_dq1;
  logic        we_n1, ce_n1, oe_n1, lb_n1, ub_n1;

  sram_access_arbiter #(.ACCESS_CYCLES(2), .ARB_MODE(0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
    .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  sram_access_arbiter #(.ACCESS_CYCLES(2), .ARB_MODE(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req1), .i_wr_addr(wr_addr1), .i_wr_data(wr_data1), .o_wr_ack(wr_ack1),
    .i_rd_req(rd_req1), .i_rd_addr(rd_addr1), .o_rd_ack(rd_ack1),
    .o_rd_data(rd_data1), .o_rd_valid(rd_valid1),
    .o_SRAM_ADDR(sram_addr1), .io_SRAM_DQ(sram_dq1),
    .o_SRAM_WE_N(we_n1), .o_SRAM_CE_N(ce_n1), .o_SRAM_OE_N(oe_n1),
    .o_SRAM_LB_N(lb_n1), .o_SRAM_UB_N(ub_n1)
  );

  // Small SRAM model: low address nibble selects the word.
  logic [15:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign sram_dq  = (!ce_n && !oe_n) ? mem[sram_addr[3:0]] : 16'hzzzz;
  assign sram_dq1 = (!ce_n1 && !oe_n1) ? 16'h7777 : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[sram_addr[3:0]] <= sram_dq;
    else if (pl_en)     mem[pl_addr] <= pl_data;
  end

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [1:0]  mon_kind;
  logic [15:0] mon_data;

  function automatic void push(input logic [1:0] k, input logic [19:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (wr_ack || rd_ack || rd_valid) begin
      mon_kind = wr_ack ? K_WACK : (rd_ack ? K_RACK : K_RVALID);
      mon_data = wr_ack ? sram_dq : rd_data;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected kind=%0d addr=%h data=%h", mon_kind, sram_addr, mon_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != mon_kind || mon_e.addr != sram_addr ||
            (mon_kind != K_RACK && mon_e.data != mon_data)) begin
          n_err++;
          $display("FAIL sb_event got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                   mon_kind, sram_addr, mon_data, mon_e.kind, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [4:0] strb();
    return {we_n, ce_n, oe_n, lb_n, ub_n};
  endfunction

  task automatic drain(input string nm);
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) cyc();
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  int acks, wcnt, rcnt, seen;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    // Reset state
    cyc(); cyc();
    chk("rst_strobes", strb(), 5'b11111);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    cyc();

    // Single write
    wr_addr = 20'h00123; wr_data = 16'hA5A5; wr_req = 1'b1;
    push(K_WACK, 20'h00123, 16'hA5A5);
    cyc(); chk("wr_c1_strobes", strb(), 5'b00100); wr_req = 1'b0;
    cyc(); chk("wr_c2_strobes", strb(), 5'b00100);
    cyc(); chk("wr_c3_recover", strb(), 5'b10100); chk("wr_c3_dq", sram_dq, 16'hA5A5);
    cyc(); chk("wr_c4_idle", strb(), 5'b11111);
    chk("wr_mem", mem[3], 16'hA5A5);

    pl_en = 1'b1; pl_addr = 4'd3; pl_data = 16'hBEEF;
    cyc(); pl_addr = 4'd6; pl_data = 16'h6666;
    cyc(); pl_en = 1'b0;

    // Single read
    rd_addr = 20'h00123; rd_req = 1'b1;
    push(K_RACK, 20'h00123, 16'h0000);
    push(K_RVALID, 20'h00123, 16'hBEEF);
    cyc(); chk("rd_c1_strobes", strb(), 5'b10000); rd_req = 1'b0;
    cyc(); chk("rd_c2_strobes", strb(), 5'b10000);
    cyc(); chk("rd_c3_idle", strb(), 5'b11111); chk("rd_c3_valid", rd_valid, 1);
    cyc(); chk("rd_c4_valid_low", rd_valid, 0); chk("rd_c4_data_held", rd_data, 16'hBEEF);
    drain("rd_drain");

    // Round-robin tie from reset: W,R,W,R
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    wr_addr = 20'h00005; wr_data = 16'h1111; rd_addr = 20'h00006;
    wr_req = 1'b1; rd_req = 1'b1;
    push(K_WACK, 20'h00005, 16'h1111);
    push(K_RACK, 20'h00006, 16'h0000);
    push(K_RVALID, 20'h00006, 16'h6666);
    push(K_WACK, 20'h00005, 16'h1111);
    push(K_RACK, 20'h00006, 16'h0000);
    push(K_RVALID, 20'h00006, 16'h6666);
    acks = 0;
    for (int t = 0; t < 40 && acks < 4; t++) begin
      cyc();
      if (wr_ack || rd_ack) acks++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("arb0_grants", acks, 4);
    drain("arb0_drain");

    // Reset during the second WRITE cycle, read pending
    cyc();
    wr_addr = 20'h00009; wr_data = 16'h9999; wr_req = 1'b1;
    push(K_WACK, 20'h00009, 16'h9999);
    cyc(); chk("rstw_c1_strobes", strb(), 5'b00100);
    wr_req = 1'b0; rd_addr = 20'h00003; rd_req = 1'b1;
    cyc(); chk("rstw_c2_strobes", strb(), 5'b00100); rst = 1'b1;
    cyc(); chk("rstw_c3_strobes", strb(), 5'b11111); chk("rstw_c3_wr_ack", wr_ack, 0);
    rst = 1'b0;
    push(K_RACK, 20'h00003, 16'h0000);
    push(K_RVALID, 20'h00003, 16'hBEEF);
    cyc(); chk("rstw_c4_rd_ack", rd_ack, 1); rd_req = 1'b0;
    drain("rstw_drain");

    // Write-priority instance: both held, only writes granted
    cyc();
    wr_req1 = 1'b1; rd_req1 = 1'b1;
    wcnt = 0; rcnt = 0;
    for (int t = 0; t < 20; t++) begin
      cyc();
      if (wr_ack1) wcnt++;
      if (rd_ack1) rcnt++;
    end
    chk("arb1_writes", wcnt, 5);
    chk("arb1_reads", rcnt, 0);
    wr_req1 = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && seen == 0; t++) begin
      cyc();
      if (rd_ack1) seen = 1;
    end
    chk("arb1_read_after_release", seen, 1);
    rd_req1 = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && seen == 0; t++) begin
      cyc();
      if (rd_valid1) seen = 1;
    end
    chk("arb1_read_valid", seen, 1);
    chk("arb1_read_data", rd_data1, 16'h7777);

    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
